// File: rtl/pe_weight_loader.sv
// Weight/bias stream distributor for the 3x3 convolution PE cores.
// Consumes one valid/ready word stream and hands each requested core nine
// serial weight shifts followed by one bias load, using one-hot strobes.
// All outputs are registered and change on the edge that accepts a beat.

module pe_weight_loader #(
    parameter int unsigned WEIGHT_WIDTH  = 16,
    parameter int unsigned FEATURE_WIDTH = 16,
    parameter int unsigned BIAS_WIDTH    = WEIGHT_WIDTH + FEATURE_WIDTH,
    parameter int unsigned KERNEL_SIZE   = 9,
    parameter int unsigned CORE_NUM      = 8,
    parameter int unsigned CNT_WIDTH     = $clog2(CORE_NUM + 1)
) (
    input  logic                    DSP_clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_WIDTH-1:0]    cfg_core_num,
    input  logic [BIAS_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [WEIGHT_WIDTH-1:0] weight,
    output logic [CORE_NUM-1:0]     weight_valid,
    output logic [BIAS_WIDTH-1:0]   bias,
    output logic [CORE_NUM-1:0]     bias_valid,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned WCntWidth = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StLoadW,
        StLoadB,
        StDone
    } state_e;

    state_e                 state_q;
    logic [WCntWidth-1:0]   w_cnt_q;
    logic [CNT_WIDTH-1:0]   core_idx_q;
    logic [CNT_WIDTH-1:0]   num_q;

    logic                   beat;
    logic                   last_weight;
    logic                   last_core;
    logic [CORE_NUM-1:0]    core_sel;
    logic [CNT_WIDTH-1:0]   cfg_num_clamped;

    // Beat acceptance, strobe target and load-boundary decodes
    always_comb begin
        beat            = s_valid && s_ready;
        last_weight     = (w_cnt_q == WCntWidth'(KERNEL_SIZE - 1));
        last_core       = (core_idx_q == (num_q - CNT_WIDTH'(1)));
        core_sel        = CORE_NUM'(1) << core_idx_q;
        cfg_num_clamped = (cfg_core_num > CNT_WIDTH'(CORE_NUM)) ? CNT_WIDTH'(CORE_NUM)
                                                                 : cfg_core_num;
    end

    // Load sequencer with registered strobes, data and handshake outputs
    always_ff @(posedge DSP_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            w_cnt_q      <= '0;
            core_idx_q   <= '0;
            num_q        <= '0;
            weight       <= '0;
            weight_valid <= '0;
            bias         <= '0;
            bias_valid   <= '0;
            done         <= 1'b0;
            s_ready      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // Strobes and done are single-cycle unless re-issued below
            weight_valid <= '0;
            bias_valid   <= '0;
            done         <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (cfg_core_num == '0) begin
                            state_q <= StDone;
                            s_ready <= 1'b0;
                        end else begin
                            state_q    <= StLoadW;
                            s_ready    <= 1'b1;
                            num_q      <= cfg_num_clamped;
                            core_idx_q <= '0;
                            w_cnt_q    <= '0;
                        end
                    end
                end
                StLoadW: begin
                    if (beat) begin
                        weight       <= s_data[WEIGHT_WIDTH-1:0];
                        weight_valid <= core_sel;
                        if (last_weight) begin
                            w_cnt_q <= '0;
                            state_q <= StLoadB;
                        end else begin
                            w_cnt_q <= w_cnt_q + WCntWidth'(1);
                        end
                    end
                end
                StLoadB: begin
                    if (beat) begin
                        bias       <= s_data;
                        bias_valid <= core_sel;
                        if (last_core) begin
                            // Drop ready on the final beat so no extra word is taken
                            state_q <= StDone;
                            s_ready <= 1'b0;
                        end else begin
                            core_idx_q <= core_idx_q + CNT_WIDTH'(1);
                            state_q    <= StLoadW;
                        end
                    end
                end
                StDone: begin
                    // Done lands one cycle after the final bias strobe
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_weight_loader.sv
// Scoreboard bench for pe_weight_loader: each load pushes its expected strobe
// sequence, a negedge monitor pops and compares, and a per-core shift-register
// model checks the kernel each core would end up holding.

module tb_pe_weight_loader;

    localparam int W  = 16;
    localparam int F  = 16;
    localparam int B  = W + F;
    localparam int K  = 9;
    localparam int C  = 8;
    localparam int CW = $clog2(C + 1);

    logic          DSP_clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_core_num = '0;
    logic [B-1:0]  s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  weight;
    logic [C-1:0]  weight_valid;
    logic [B-1:0]  bias;
    logic [C-1:0]  bias_valid;
    logic          busy;
    logic          done;

    pe_weight_loader #(
        .WEIGHT_WIDTH (W),
        .FEATURE_WIDTH(F),
        .BIAS_WIDTH   (B),
        .KERNEL_SIZE  (K),
        .CORE_NUM     (C),
        .CNT_WIDTH    (CW)
    ) dut (
        .DSP_clk     (DSP_clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_core_num(cfg_core_num),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .weight      (weight),
        .weight_valid(weight_valid),
        .bias        (bias),
        .bias_valid  (bias_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 DSP_clk = ~DSP_clk;

    typedef struct {
        int          kind;   // 0 weight, 1 bias, 2 done
        logic [B-1:0] val;
        logic [C-1:0] strobe;
    } ev_t;

    ev_t          exp_q[$];
    logic [B-1:0] words_q[$];
    logic [W-1:0] kern[C][K];
    logic [W-1:0] exp_kern[C][K];
    logic [B-1:0] kbias[C];
    logic [B-1:0] exp_bias[C];
    logic [W-1:0] last_w = '0;
    logic [B-1:0] last_b = '0;
    time          t_first, t_start, t_done, t_last_b;
    int           done_cnt = 0;
    int           checks = 0;
    int           failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe or done must match the head of the expected queue
    initial begin
        ev_t e;
        int  obs_kind;
        forever begin
            @(negedge DSP_clk);
            if (rst_n) begin
                if (done) begin
                    done_cnt++;
                    t_done = $time;
                end
                if (weight_valid == '0 && bias_valid == '0 && !done) begin
                    chk("weight_hold", weight, last_w);
                    chk("bias_hold", bias, last_b);
                end else begin
                    chk("strobe_onehot", {$onehot0(weight_valid), $onehot0(bias_valid),
                        !(|weight_valid && |bias_valid)}, 3'b111);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", {done, weight_valid, bias_valid}, '0);
                    end else begin
                        e = exp_q.pop_front();
                        obs_kind = done ? 2 : (|bias_valid ? 1 : 0);
                        chk("event_kind", obs_kind, e.kind);
                        if (e.kind == 0) begin
                            chk("weight_valid", weight_valid, e.strobe);
                            chk("weight", weight, e.val[W-1:0]);
                        end else if (e.kind == 1) begin
                            chk("bias_valid", bias_valid, e.strobe);
                            chk("bias", bias, e.val);
                            t_last_b = $time;
                        end else begin
                            chk("done_no_strobe", {weight_valid, bias_valid}, '0);
                        end
                    end
                    for (int k = 0; k < C; k++) begin
                        if (weight_valid[k]) begin
                            for (int j = 0; j < K - 1; j++) kern[k][j] = kern[k][j+1];
                            kern[k][K-1] = weight;
                        end
                        if (bias_valid[k]) kbias[k] = bias;
                    end
                    last_w = weight;
                    last_b = bias;
                end
            end
        end
    end

    // One load: build words and expectations, start, stream beats, then check
    task automatic do_load(input int cfg, input bit stall, input bit hold, input bit restart_mid,
                           input bit fixed, input int abort_after);
        int           num;
        int           d0;
        int           idx;
        int           guard;
        bit           restarted;
        bit           v;
        bit           a;
        logic [B-1:0] w;
        ev_t          e;
        num = (cfg > C) ? C : cfg;
        words_q.delete();
        for (int k = 0; k < num; k++) begin
            for (int j = 0; j < K; j++) begin
                w = fixed ? B'(j + 1) : B'($urandom);
                words_q.push_back(w);
                exp_kern[k][j] = w[W-1:0];
                e.kind = 0; e.val = w; e.strobe = C'(1) << k;
                exp_q.push_back(e);
            end
            w = fixed ? B'(32'h1234_5678) : B'($urandom);
            words_q.push_back(w);
            exp_bias[k] = w;
            e.kind = 1; e.val = w; e.strobe = C'(1) << k;
            exp_q.push_back(e);
        end
        e.kind = 2; e.val = '0; e.strobe = '0;
        exp_q.push_back(e);
        d0 = done_cnt;

        @(negedge DSP_clk);
        cfg_core_num = CW'(cfg);
        start = 1'b1;
        s_valid = 1'b0;
        @(posedge DSP_clk);
        t_start = $time;
        idx = 0;
        guard = 0;
        restarted = 1'b0;
        if (num == 0) begin
            @(negedge DSP_clk);
            start = 1'b0;
            chk("zero_busy_first", busy, 1);
            chk("zero_ready", s_ready, 0);
            @(negedge DSP_clk);
            chk("zero_busy_second", busy, 0);
        end else begin
            while (idx < words_q.size() && guard < 2000) begin
                guard++;
                @(negedge DSP_clk);
                start = 1'b0;
                if (restart_mid && !restarted && idx == 4) begin
                    start = 1'b1;
                    cfg_core_num = CW'(5);
                    restarted = 1'b1;
                end
                v = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                s_valid = v;
                s_data = v ? words_q[idx] : B'($urandom);
                a = v && s_ready;
                @(posedge DSP_clk);
                if (a) begin
                    if (idx == 0) t_first = $time;
                    idx++;
                end
                if (abort_after >= 0 && idx == abort_after) break;
            end
            if (guard >= 2000) chk("beat_timeout", 0, 1);
        end

        if (abort_after >= 0) begin
            @(negedge DSP_clk);
            s_valid = 1'b0;
            start = 1'b0;
            #2;
            rst_n = 1'b0;
            exp_q.delete();
            #1;
            chk("reset_outputs", {weight, weight_valid, bias, bias_valid, done, s_ready, busy}, '0);
            last_w = '0;
            last_b = '0;
            repeat (2) @(negedge DSP_clk);
            rst_n = 1'b1;
            return;
        end

        if (num > 0) begin
            @(negedge DSP_clk);
            start = 1'b0;
            s_valid = hold;
            s_data = B'($urandom);
            if (hold) begin
                chk("ready_after_last", s_ready, 0);
                repeat (3) @(negedge DSP_clk);
                s_valid = 1'b0;
            end
        end
        guard = 0;
        while (done_cnt == d0 && guard < 200) begin
            @(negedge DSP_clk);
            guard++;
        end
        repeat (3) @(negedge DSP_clk);
        #1;
        chk("done_count", done_cnt - d0, 1);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("beats_accepted", idx, (K + 1) * num);
        chk("ready_idle", s_ready, 0);
        chk("busy_idle", busy, 0);
        for (int k = 0; k < num; k++) begin
            for (int j = 0; j < K; j++) chk($sformatf("kernel[%0d][%0d]", k, j), kern[k][j],
                                            exp_kern[k][j]);
            chk($sformatf("core_bias[%0d]", k), kbias[k], exp_bias[k]);
        end
        if (num > 0) chk("done_after_bias_ns", t_done - t_last_b, 10);
        else         chk("zero_done_delay_ns", t_done - t_start, 15);
        if (fixed)   chk("single_core_total_ns", t_done - t_first, 105);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("reset_outputs_init", {weight, weight_valid, bias, bias_valid, done, s_ready, busy}, '0);
        repeat (2) @(negedge DSP_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge DSP_clk);

        do_load(1, 1'b0, 1'b0, 1'b0, 1'b1, -1);  // directed single core
        do_load(3, 1'b1, 1'b0, 1'b0, 1'b0, -1);  // stalls across three cores
        do_load(9, 1'b0, 1'b0, 1'b0, 1'b0, -1);  // clamp to CORE_NUM
        do_load(0, 1'b0, 1'b0, 1'b0, 1'b0, -1);  // zero cores
        do_load(2, 1'b1, 1'b0, 1'b1, 1'b0, -1);  // start while busy
        do_load(2, 1'b0, 1'b0, 1'b0, 1'b0, 14);  // reset after beat 4 of core 1
        do_load(1, 1'b0, 1'b0, 1'b0, 1'b0, -1);  // clean reload after reset
        do_load(2, 1'b0, 1'b1, 1'b0, 1'b0, -1);  // valid held past the last beat
        for (int i = 0; i < 3; i++) begin
            do_load(int'($urandom_range(1, C)), 1'b1, 1'(i % 2), 1'b0, 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
